// File: rtl/lemming_pkg.sv
// Shared constants, move encoding and terrain-map helper for the lemming world model.
package lemming_pkg;

    localparam int COLS      = 16;
    localparam int HGT_W     = 4;
    localparam int MAX_DEPTH = (1 << HGT_W) - 1;
    localparam int MAX_COLS  = 256;
    localparam int MAP_W     = MAX_COLS * HGT_W;

    // Which movement rule fired on this edge; earlier entries take priority.
    typedef enum logic [2:0] {
        MV_SPAWN,
        MV_FALL,
        MV_DIG,
        MV_LEFT,
        MV_RIGHT,
        MV_HOLD
    } move_e;

    // Extracts the floor depth of column idx from a packed floor map (zero-extended to MAP_W).
    function automatic logic [HGT_W-1:0] col_floor(input logic [MAP_W-1:0] map,
                                                   input int unsigned    idx);
        return map[idx*HGT_W +: HGT_W];
    endfunction

endpackage

// File: rtl/lemming_terrain_if.sv
// Walker <-> terrain signal bundle plus the terrain config write port.
interface lemming_terrain_if #(
    parameter int COL_W = 4,
    parameter int HGT_W = 4
);
    logic             walk_left;
    logic             walk_right;
    logic             aaah;
    logic             digging;
    logic             spawn;
    logic             cfg_we;
    logic [COL_W-1:0] cfg_col;
    logic [HGT_W-1:0] cfg_floor;
    logic             cfg_wall;
    logic             ground;
    logic             bump_left;
    logic             bump_right;
    logic [COL_W-1:0] pos_x;
    logic [HGT_W-1:0] pos_y;
    logic             at_exit;

    modport master (
        output walk_left, walk_right, aaah, digging, spawn,
        output cfg_we, cfg_col, cfg_floor, cfg_wall,
        input  ground, bump_left, bump_right, pos_x, pos_y, at_exit
    );

    modport slave (
        input  walk_left, walk_right, aaah, digging, spawn,
        input  cfg_we, cfg_col, cfg_floor, cfg_wall,
        output ground, bump_left, bump_right, pos_x, pos_y, at_exit
    );

endinterface

// File: rtl/lemming_terrain_map.sv
// Per-column floor/wall register file: one write port (cfg over dig) and
// three combinational read ports around the lemming column.
module terrain_map #(
    parameter int                     COLS       = 16,
    parameter int                     COL_W      = 4,
    parameter int                     HGT_W      = 4,
    parameter logic [COLS*HGT_W-1:0]  FLOOR_INIT = '0,
    parameter logic [COLS-1:0]        WALL_INIT  = '0
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             cfg_we_i,
    input  logic [COL_W-1:0] cfg_col_i,
    input  logic [HGT_W-1:0] cfg_floor_i,
    input  logic             cfg_wall_i,
    input  logic             dig_i,
    input  logic [COL_W-1:0] x_i,
    output logic [HGT_W-1:0] floor_l_o,
    output logic [HGT_W-1:0] floor_c_o,
    output logic [HGT_W-1:0] floor_r_o,
    output logic             wall_l_o,
    output logic             wall_r_o
);

    logic [HGT_W-1:0] floor_q [COLS];
    logic [HGT_W-1:0] floor_d [COLS];
    logic [COLS-1:0]  wall_q;
    logic [COLS-1:0]  wall_d;

    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        floor_d = floor_q;
        wall_d  = wall_q;
        if (dig_i) begin
            floor_d[x_i] = floor_q[x_i] + HGT_W'(1);
        end
        // Applied after the dig so a same-column config write wins.
        if (cfg_we_i && (int'(cfg_col_i) < COLS)) begin
            floor_d[cfg_col_i] = cfg_floor_i;
            wall_d[cfg_col_i]  = cfg_wall_i;
        end
    end

    // NOTE: this array is flops holding the preloaded terrain, not a RAM, so reset restores it.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int c = 0; c < COLS; c++) begin
                floor_q[c] <= FLOOR_INIT[c*HGT_W +: HGT_W];
            end
            wall_q <= WALL_INIT;
        end else begin
            floor_q <= floor_d;
            wall_q  <= wall_d;
        end
    end

    // Reads past either end of the world look like a solid wall.
    always_comb begin
        floor_c_o = floor_q[x_i];
        floor_l_o = '0;
        wall_l_o  = 1'b1;
        floor_r_o = '0;
        wall_r_o  = 1'b1;
        if (x_i != '0) begin
            floor_l_o = floor_q[x_i - COL_W'(1)];
            wall_l_o  = wall_q[x_i - COL_W'(1)];
        end
        if (int'(x_i) < COLS - 1) begin
            floor_r_o = floor_q[x_i + COL_W'(1)];
            wall_r_o  = wall_q[x_i + COL_W'(1)];
        end
    end

endmodule

// File: rtl/lemming_terrain.sv
// 1-D world model closing the loop with the Lemmings walker: tracks lemming
// position, applies movement/dig rules and feeds ground/bump back.
module lemming_terrain #(
    parameter int                     COLS       = lemming_pkg::COLS,
    parameter int                     COL_W      = $clog2(COLS),
    parameter int                     HGT_W      = lemming_pkg::HGT_W,
    parameter logic [COLS*HGT_W-1:0]  FLOOR_INIT = '0,
    parameter logic [COLS-1:0]        WALL_INIT  = '0,
    parameter int                     SPAWN_X    = 0,
    parameter int                     EXIT_X     = COLS - 1
) (
    input  logic               clk,
    input  logic               areset_n,
    lemming_terrain_if.slave   bus
);

    import lemming_pkg::*;

    localparam logic [HGT_W-1:0] BEDROCK = '1;

    logic [COL_W-1:0] x_q, x_d;
    logic [HGT_W-1:0] y_q, y_d;
    logic [HGT_W-1:0] floor_l, floor_c, floor_r;
    logic             wall_l, wall_r;
    logic             ground, bump_l, bump_r;
    move_e            move;

    terrain_map #(
        .COLS       (COLS),
        .COL_W      (COL_W),
        .HGT_W      (HGT_W),
        .FLOOR_INIT (FLOOR_INIT),
        .WALL_INIT  (WALL_INIT)
    ) u_map (
        .clk         (clk),
        .areset_n    (areset_n),
        .cfg_we_i    (bus.cfg_we),
        .cfg_col_i   (bus.cfg_col),
        .cfg_floor_i (bus.cfg_floor),
        .cfg_wall_i  (bus.cfg_wall),
        .dig_i       (move == MV_DIG),
        .x_i         (x_q),
        .floor_l_o   (floor_l),
        .floor_c_o   (floor_c),
        .floor_r_o   (floor_r),
        .wall_l_o    (wall_l),
        .wall_r_o    (wall_r)
    );

    // A shallower neighbour blocks like a wall; a deeper one is walked onto and fallen into.
    assign ground = (y_q == floor_c);
    assign bump_l = wall_l || (floor_l < y_q);
    assign bump_r = wall_r || (floor_r < y_q);

    always_comb begin
        move = MV_HOLD;
        if (bus.spawn) begin
            move = MV_SPAWN;
        end else if (bus.aaah && (y_q < floor_c)) begin
            move = MV_FALL;
        end else if (bus.digging && ground && (floor_c != BEDROCK)) begin
            move = MV_DIG;
        end else if (bus.walk_left && !bus.walk_right && !bump_l) begin
            move = MV_LEFT;
        end else if (bus.walk_right && !bus.walk_left && !bump_r) begin
            move = MV_RIGHT;
        end
    end

    // Falls only happen while y < floor <= BEDROCK, so y cannot overflow; bumps stop x wrapping.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (move)
            MV_SPAWN: begin
                x_d = COL_W'(SPAWN_X);
                y_d = '0;
            end
            MV_FALL:  y_d = y_q + HGT_W'(1);
            MV_LEFT:  x_d = x_q - COL_W'(1);
            MV_RIGHT: x_d = x_q + COL_W'(1);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            x_q <= COL_W'(SPAWN_X);
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign bus.ground     = ground;
    assign bus.bump_left  = bump_l;
    assign bus.bump_right = bump_r;
    assign bus.pos_x      = x_q;
    assign bus.pos_y      = y_q;
    assign bus.at_exit    = ground && (int'(x_q) == EXIT_X);

endmodule

// File: tb/tb_lemming_terrain.sv
// Closed-loop bench: walker FSM + random stimulus against a column/depth reference model.
module tb_lemming_terrain;

    localparam int                COLS       = 12;
    localparam int                COL_W      = 4;
    localparam int                HGT_W      = 4;
    localparam int                MAXD       = 15;
    localparam int                SPAWN_X    = 0;
    localparam int                EXIT_X     = COLS - 1;
    localparam logic [COLS*4-1:0] FLOOR_INIT = 48'h0020_0000_0000;  // column 9 at depth 2
    localparam logic [COLS-1:0]   WALL_INIT  = 12'h020;             // column 5 is a wall
    localparam int                MAP_W      = lemming_pkg::MAP_W;

    logic clk;
    logic areset_n;

    lemming_terrain_if #(.COL_W(COL_W), .HGT_W(HGT_W)) bus ();

    lemming_terrain #(
        .COLS       (COLS),
        .HGT_W      (HGT_W),
        .FLOOR_INIT (FLOOR_INIT),
        .WALL_INIT  (WALL_INIT),
        .SPAWN_X    (SPAWN_X),
        .EXIT_X     (EXIT_X)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus registers ----------------
    logic             use_walker;
    logic             dig_req;
    logic             r_wl, r_wr, r_aaah, r_dig, r_spawn;
    logic             r_cfg_we, r_cfg_wall;
    logic [COL_W-1:0] r_cfg_col;
    logic [HGT_W-1:0] r_cfg_floor;

    // ---------------- Lemmings walker (walk / fall / dig) ----------------
    typedef enum logic [2:0] {WL, WR, FL, FR, DL, DR} wstate_e;
    wstate_e ws;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            ws <= WL;
        end else begin
            case (ws)
                WL: if (!bus.ground) ws <= FL; else if (dig_req) ws <= DL; else if (bus.bump_left) ws <= WR;
                WR: if (!bus.ground) ws <= FR; else if (dig_req) ws <= DR; else if (bus.bump_right) ws <= WL;
                FL: if (bus.ground) ws <= WL;
                FR: if (bus.ground) ws <= WR;
                DL: if (!bus.ground) ws <= FL;
                DR: if (!bus.ground) ws <= FR;
                default: ws <= WL;
            endcase
        end
    end

    always_comb begin
        bus.walk_left  = use_walker ? (ws == WL) : r_wl;
        bus.walk_right = use_walker ? (ws == WR) : r_wr;
        bus.aaah       = use_walker ? (ws == FL || ws == FR) : r_aaah;
        bus.digging    = use_walker ? (ws == DL || ws == DR) : r_dig;
        bus.spawn      = r_spawn;
        bus.cfg_we     = r_cfg_we;
        bus.cfg_col    = r_cfg_col;
        bus.cfg_floor  = r_cfg_floor;
        bus.cfg_wall   = r_cfg_wall;
    end

    // ---------------- reference world model ----------------
    int mx, my;
    int mfloor [COLS];
    bit mwall  [COLS];

    function automatic bit m_ground();
        return my == mfloor[mx];
    endfunction

    function automatic bit m_bump_left();
        if (mx == 0) return 1'b1;
        return mwall[mx-1] || (mfloor[mx-1] < my);
    endfunction

    function automatic bit m_bump_right();
        if (mx == COLS - 1) return 1'b1;
        return mwall[mx+1] || (mfloor[mx+1] < my);
    endfunction

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mx <= SPAWN_X;
            my <= 0;
            for (int c = 0; c < COLS; c++) begin
                mfloor[c] <= int'(lemming_pkg::col_floor(MAP_W'(FLOOR_INIT), c));
                mwall[c]  <= WALL_INIT[c];
            end
        end else begin
            if (bus.spawn) begin
                mx <= SPAWN_X;
                my <= 0;
            end else if (bus.aaah && my < mfloor[mx]) begin
                my <= my + 1;
            end else if (bus.digging && m_ground() && mfloor[mx] < MAXD) begin
                mfloor[mx] <= mfloor[mx] + 1;
            end else if (bus.walk_left && !bus.walk_right && !m_bump_left()) begin
                mx <= mx - 1;
            end else if (bus.walk_right && !bus.walk_left && !m_bump_right()) begin
                mx <= mx + 1;
            end
            if (bus.cfg_we && bus.cfg_col < COLS) begin
                mfloor[bus.cfg_col] <= int'(bus.cfg_floor);
                mwall[bus.cfg_col]  <= bus.cfg_wall;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("pos_x",      bus.pos_x,      mx);
        check("pos_y",      bus.pos_y,      my);
        check("ground",     bus.ground,     m_ground());
        check("bump_left",  bus.bump_left,  m_bump_left());
        check("bump_right", bus.bump_right, m_bump_right());
        check("at_exit",    bus.at_exit,    (mx == EXIT_X) && m_ground());
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cfg_write(input int col, input int fl, input bit wall);
        r_cfg_we    = 1'b1;
        r_cfg_col   = COL_W'(col);
        r_cfg_floor = HGT_W'(fl);
        r_cfg_wall  = wall;
        step();
        r_cfg_we    = 1'b0;
    endtask

    // Random config write that never leaves the lemming's column or a neighbour above its depth.
    task automatic rand_cfg();
        int col, hi;
        col = int'($urandom_range(15, 0));
        hi  = (my + 3 > MAXD) ? MAXD : my + 3;
        r_cfg_we    = 1'b1;
        r_cfg_col   = COL_W'(col);
        r_cfg_wall  = ($urandom_range(3, 0) == 0);
        if (col >= mx - 1 && col <= mx + 1) r_cfg_floor = HGT_W'($urandom_range(hi, my));
        else                                r_cfg_floor = HGT_W'($urandom_range(4, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq [7] = '{0, 1, 2, 3, 4, 4, 3};
        bit found;
        int dcol, y0, tgt;

        use_walker = 1'b1; dig_req = 1'b0;
        r_wl = 0; r_wr = 0; r_aaah = 0; r_dig = 0; r_spawn = 0;
        r_cfg_we = 0; r_cfg_col = '0; r_cfg_floor = '0; r_cfg_wall = 0;
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        #7;
        check("rst_pos_x", bus.pos_x, 0);
        check("rst_pos_y", bus.pos_y, 0);
        check("rst_ground", bus.ground, 1);
        check("rst_bump_left", bus.bump_left, 1);
        @(negedge clk);
        areset_n = 1'b1;

        // Walker bumps the left edge, walks right to the column-5 wall, turns.
        for (int i = 0; i < 7; i++) begin
            step();
            check("walk_seq", bus.pos_x, exp_seq[i]);
        end

        // Drop: clear wall 5, pit of depth 3 at column 6 backed by a wall at 7.
        cfg_write(5, 0, 0);
        cfg_write(6, 3, 0);
        cfg_write(7, 0, 1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.pos_x == 6) found = 1;
        end
        check("reach_x6", found, 1);
        check("drop_ground0", bus.ground, 0);
        step();
        check("drop_aaah", bus.aaah, 1);
        check("drop_y0", bus.pos_y, 0);
        for (int d = 1; d <= 3; d++) begin
            step();
            check("drop_y", bus.pos_y, d);
            check("drop_x", bus.pos_x, 6);
        end
        check("drop_land", bus.ground, 1);
        step();
        check("drop_resume", bus.walk_left | bus.walk_right, 1);

        // Step-up: shallower column 5 acts as a wall from depth 3.
        for (int i = 0; i < 10; i++) begin
            step();
            check("stepup_bump", bus.bump_left, 1);
            check("stepup_x", bus.pos_x, 6);
        end

        // Dig one level near the spawn column.
        r_spawn = 1'b1; step(); r_spawn = 1'b0;
        check("spawn_x", bus.pos_x, SPAWN_X);
        check("spawn_y", bus.pos_y, 0);
        dig_req = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.digging && bus.ground) found = 1;
        end
        check("dig_start", found, 1);
        dig_req = 1'b0;
        dcol = int'(bus.pos_x);
        step();
        check("dig_ground0", bus.ground, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bus.pos_y == 1 && bus.ground) found = 1;
        end
        check("dig_fall_y1", found, 1);
        step();
        check("dig_resume", bus.walk_left | bus.walk_right, 1);

        // Bedrock: depth saturates and digging continues.
        cfg_write(dcol, MAXD, 0);
        dig_req = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("bedrock_y", bus.pos_y, MAXD);
        check("bedrock_dig", bus.digging, 1);
        check("bedrock_ground", bus.ground, 1);
        dig_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bedrock_hold_y", bus.pos_y, MAXD);
        check("bedrock_hold_dig", bus.digging, 1);

        // Config write on the same edge as a dig on that column: config value stored.
        r_spawn = 1'b1; step(); r_spawn = 1'b0;
        cfg_write(dcol, 0, 0);
        dig_req = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (bus.digging && bus.ground) found = 1;
        end
        check("conflict_dig", found, 1);
        y0  = int'(bus.pos_y);
        tgt = y0 + 5;
        dig_req     = 1'b0;
        r_cfg_we    = 1'b1;
        r_cfg_col   = bus.pos_x;
        r_cfg_floor = HGT_W'(tgt);
        r_cfg_wall  = 1'b0;
        step();
        r_cfg_we = 1'b0;
        check("conflict_ground0", bus.ground, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.ground) found = 1;
        end
        check("conflict_land", found, 1);
        check("conflict_cfg_wins", bus.pos_y, tgt);

        // Spawn while falling.
        cfg_write(int'(bus.pos_x), tgt + 5, 0);
        found = 0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (bus.pos_y == tgt + 2) found = 1;
        end
        check("fall_reach", found, 1);
        r_spawn = 1'b1; step(); r_spawn = 1'b0;
        check("fall_spawn_x", bus.pos_x, SPAWN_X);
        check("fall_spawn_y", bus.pos_y, 0);

        // Asynchronous reset between edges restores position and terrain.
        @(negedge clk);
        #2 areset_n = 1'b0;
        #1;
        check("areset_x", bus.pos_x, SPAWN_X);
        check("areset_y", bus.pos_y, 0);
        check("areset_ground", bus.ground, 1);
        check("areset_bump_right", bus.bump_right, 0);
        @(negedge clk);
        areset_n = 1'b1;

        // Random raw walker signals, including the illegal both-directions case.
        use_walker = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int dir;
            dir     = int'($urandom_range(7, 0));
            r_wl    = (dir <= 2) || (dir == 6);
            r_wr    = (dir >= 3 && dir <= 5) || (dir == 6);
            r_aaah  = ($urandom_range(2, 0) == 0);
            r_dig   = ($urandom_range(3, 0) == 0);
            r_spawn = ($urandom_range(31, 0) == 0);
            if ($urandom_range(7, 0) == 0) rand_cfg();
            else r_cfg_we = 1'b0;
            step();
        end
        r_wl = 0; r_wr = 0; r_aaah = 0; r_dig = 0; r_spawn = 0; r_cfg_we = 0;

        // Random terrain edits and dig requests with the walker in the loop.
        use_walker = 1'b1;
        for (int i = 0; i < 400; i++) begin
            dig_req = ($urandom_range(7, 0) == 0);
            r_spawn = ($urandom_range(63, 0) == 0);
            if ($urandom_range(15, 0) == 0) rand_cfg();
            else r_cfg_we = 1'b0;
            step();
        end
        dig_req = 0; r_spawn = 0; r_cfg_we = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
